// File: rtl/ex_div_ctrl.sv
// EX-stage radix-2 restoring divider and sequencer for DIV/DIVU/REM/REMU.
// Latency 33 cycles on the normal path, 1 cycle for divide-by-zero/overflow; stalls the pipe while busy.
module ex_div_ctrl #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 5
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start_i,
  input  logic [1:0]      op_i,
  input  logic [XLEN-1:0] dividend_i,
  input  logic [XLEN-1:0] divisor_i,
  input  logic            annul_i,
  output logic            stall_req_o,
  output logic            busy_o,
  output logic            done_o,
  output logic [XLEN-1:0] result_o
);

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_DONE} state_t;

  localparam logic [XLEN-1:0] ALL_ONES = {XLEN{1'b1}};
  localparam logic [XLEN-1:0] INT_MIN  = {1'b1, {(XLEN-1){1'b0}}};

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              is_rem_q, is_rem_d;
  logic              neg_quo_q, neg_quo_d;
  logic              neg_rem_q, neg_rem_d;
  logic [XLEN-1:0]   dvd_q, dvd_d;
  logic [XLEN-1:0]   dvs_q, dvs_d;
  logic [XLEN-1:0]   rem_q, rem_d;
  logic [XLEN-1:0]   quo_q, quo_d;
  logic [XLEN-1:0]   result_q, result_d;
  logic              busy_q, busy_d;

  logic              is_signed, is_rem, a_neg, b_neg;
  logic [XLEN-1:0]   a_mag, b_mag;
  logic              div_zero, ovf, accept;
  logic [XLEN-1:0]   special_res;
  logic [XLEN:0]     rem_sh, diff;
  logic              q_bit;
  logic [XLEN-1:0]   rem_step, quo_step, quo_fix, rem_fix;

  // Operand decode; the magnitude of INT_MIN wraps to itself and is used as unsigned.
  always_comb begin
    is_signed   = ~op_i[0];
    is_rem      = op_i[1];
    a_neg       = is_signed & dividend_i[XLEN-1];
    b_neg       = is_signed & divisor_i[XLEN-1];
    a_mag       = a_neg ? (~dividend_i + 1'b1) : dividend_i;
    b_mag       = b_neg ? (~divisor_i + 1'b1) : divisor_i;
    div_zero    = (divisor_i == '0);
    ovf         = is_signed & (dividend_i == INT_MIN) & (divisor_i == ALL_ONES);
    special_res = '0;
    if (div_zero)   special_res = is_rem ? dividend_i : ALL_ONES;
    else if (ovf)   special_res = is_rem ? '0 : INT_MIN;
    accept      = (state_q == S_IDLE) & start_i & ~annul_i;
  end

  // One shift-subtract step; the 33-bit difference sign selects the quotient bit.
  always_comb begin
    rem_sh   = {rem_q, dvd_q[XLEN-1]};
    diff     = rem_sh - {1'b0, dvs_q};
    q_bit    = ~diff[XLEN];
    rem_step = q_bit ? diff[XLEN-1:0] : rem_sh[XLEN-1:0];
    quo_step = {quo_q[XLEN-2:0], q_bit};
    quo_fix  = neg_quo_q ? (~quo_step + 1'b1) : quo_step;
    rem_fix  = neg_rem_q ? (~rem_step + 1'b1) : rem_step;
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    is_rem_d  = is_rem_q;
    neg_quo_d = neg_quo_q;
    neg_rem_d = neg_rem_q;
    dvd_d     = dvd_q;
    dvs_d     = dvs_q;
    rem_d     = rem_q;
    quo_d     = quo_q;
    result_d  = result_q;

    case (state_q)
      S_IDLE: begin
        if (accept) begin
          is_rem_d  = is_rem;
          neg_quo_d = (op_i == 2'b00) & (a_neg ^ b_neg);
          neg_rem_d = (op_i == 2'b10) & a_neg;
          dvd_d     = a_mag;
          dvs_d     = b_mag;
          if (div_zero || ovf) begin
            result_d = special_res;
            state_d  = S_DONE;
          end else begin
            rem_d   = '0;
            quo_d   = '0;
            cnt_d   = '0;
            state_d = S_CALC;
          end
        end
      end
      S_CALC: begin
        if (annul_i) begin
          state_d = S_IDLE;
        end else begin
          rem_d = rem_step;
          quo_d = quo_step;
          dvd_d = {dvd_q[XLEN-2:0], 1'b0};
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_q == CNT_W'(XLEN-1)) begin
            result_d = is_rem_q ? rem_fix : quo_fix;
            state_d  = S_DONE;
          end
        end
      end
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    busy_d = (state_d == S_CALC);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      is_rem_q  <= 1'b0;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
      dvd_q     <= '0;
      dvs_q     <= '0;
      rem_q     <= '0;
      quo_q     <= '0;
      result_q  <= '0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      is_rem_q  <= is_rem_d;
      neg_quo_q <= neg_quo_d;
      neg_rem_q <= neg_rem_d;
      dvd_q     <= dvd_d;
      dvs_q     <= dvs_d;
      rem_q     <= rem_d;
      quo_q     <= quo_d;
      result_q  <= result_d;
      busy_q    <= busy_d;
    end
  end

  assign stall_req_o = accept | (state_q == S_CALC);
  assign busy_o      = busy_q;
  assign done_o      = (state_q == S_DONE) & ~annul_i;
  assign result_o    = result_q;

endmodule

// File: tb/tb_ex_div_ctrl.sv
// Bench for ex_div_ctrl: directed corner cases plus random operations checked against an arithmetic model.
module tb_ex_div_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        start_i;
  logic [1:0]  op_i;
  logic [31:0] dividend_i;
  logic [31:0] divisor_i;
  logic        annul_i;
  logic        stall_req_o;
  logic        busy_o;
  logic        done_o;
  logic [31:0] result_o;

  int n_cmp = 0;
  int n_bad = 0;

  ex_div_ctrl #(.XLEN(32), .CNT_W(5)) dut (
    .clk(clk), .rst(rst), .start_i(start_i), .op_i(op_i),
    .dividend_i(dividend_i), .divisor_i(divisor_i), .annul_i(annul_i),
    .stall_req_o(stall_req_o), .busy_o(busy_o), .done_o(done_o), .result_o(result_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // RISC-V M-extension semantics in plain integer arithmetic.
  function automatic logic [31:0] ref_div(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    int sa, sb;
    logic ovf;
    sa  = int'(a);
    sb  = int'(b);
    ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    case (op)
      2'b00:   return (b == 0) ? 32'hFFFF_FFFF : (ovf ? 32'h8000_0000 : 32'(sa / sb));
      2'b01:   return (b == 0) ? 32'hFFFF_FFFF : a / b;
      2'b10:   return (b == 0) ? a : (ovf ? 32'h0 : 32'(sa % sb));
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  // mode: 0 normal, 1 annul in CALC cycle 10, 2 reset in CALC cycle 20, 3 annul in DONE
  task automatic run(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b, input int mode);
    logic [31:0] exp, prev;
    bit spec, got;
    int cyc, stl, bsy, n_calc;
    exp    = ref_div(op, a, b);
    spec   = (b == 0) || (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF);
    n_calc = spec ? 0 : 32;
    prev   = result_o;
    op_i = op; dividend_i = a; divisor_i = b; start_i = 1'b1; annul_i = 1'b0;
    #1 chk("stall_at_start", 32'(stall_req_o), 32'd1);
    stl = 1; bsy = 0; cyc = 0; got = 0;
    while (!got && cyc < 40) begin
      @(negedge clk);
      cyc++;
      if (mode == 3 && cyc == n_calc + 1) begin
        annul_i = 1'b1;
        #1 chk("done_annulled", 32'(done_o), 32'd0);
        chk("result_annul_done", result_o, exp);
        @(negedge clk);
        annul_i = 1'b0; start_i = 1'b0;
        #1 chk("idle_after_done_annul", {29'd0, busy_o, stall_req_o, done_o}, 32'd0);
        return;
      end
      if (done_o) got = 1;
      else begin
        stl += int'(stall_req_o);
        bsy += int'(busy_o);
      end
      if (mode == 1 && cyc == 10) begin
        annul_i = 1'b1;
        @(negedge clk);
        annul_i = 1'b0; start_i = 1'b0;
        #1 chk("idle_after_calc_annul", {29'd0, busy_o, stall_req_o, done_o}, 32'd0);
        chk("result_kept_annul", result_o, prev);
        repeat (3) begin
          @(negedge clk);
          chk("no_done_after_annul", 32'(done_o), 32'd0);
        end
        return;
      end
      if (mode == 2 && cyc == 20) begin
        rst = 1'b1;
        @(negedge clk);
        start_i = 1'b0;
        #1 chk("outs_after_rst", {28'd0, busy_o, stall_req_o, done_o, 1'b0}, 32'd0);
        chk("result_after_rst", result_o, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        chk("no_done_after_rst", 32'(done_o), 32'd0);
        return;
      end
      if (!got) begin
        dividend_i = $urandom;
        divisor_i  = $urandom;
        op_i       = 2'($urandom);
      end
    end
    chk("done_seen", 32'(got), 32'd1);
    chk("latency", 32'(cyc), 32'(n_calc + 1));
    chk("stall_cycles", 32'(stl), 32'(n_calc + 1));
    chk("busy_cycles", 32'(bsy), 32'(n_calc));
    chk("result", result_o, exp);
    @(negedge clk);
    chk("done_single", 32'(done_o), 32'd0);
    start_i = 1'b0;
    #1 chk("stall_idle", 32'(stall_req_o), 32'd0);
    chk("result_held", result_o, exp);
  endtask

  initial begin
    rst = 1'b1; start_i = 1'b0; op_i = 2'b00; dividend_i = '0; divisor_i = '0; annul_i = 1'b0;
    repeat (2) @(negedge clk);
    chk("reset_outs", {29'd0, busy_o, stall_req_o, done_o}, 32'd0);
    chk("reset_result", result_o, 32'd0);
    rst = 1'b0;
    @(negedge clk);

    run(2'b01, 32'd100, 32'd7, 0);
    run(2'b11, 32'd100, 32'd7, 0);
    run(2'b00, 32'hFFFF_FFF9, 32'd2, 0);
    run(2'b10, 32'hFFFF_FFF9, 32'd2, 0);
    run(2'b00, 32'd7, 32'hFFFF_FFFE, 0);
    run(2'b10, 32'd7, 32'hFFFF_FFFE, 0);
    run(2'b01, 32'h1234_5678, 32'd0, 0);
    run(2'b11, 32'h1234_5678, 32'd0, 0);
    run(2'b00, 32'h8000_0000, 32'hFFFF_FFFF, 0);
    run(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 0);
    run(2'b01, 32'h8000_0000, 32'hFFFF_FFFF, 0);
    run(2'b00, 32'h8000_0000, 32'd3, 0);
    run(2'b01, 32'd1000, 32'd3, 1);
    run(2'b01, 32'd9, 32'd3, 0);
    run(2'b01, 32'd5555, 32'd7, 2);
    run(2'b01, 32'hFFFF_FFFF, 32'd1, 0);
    run(2'b01, 32'd1, 32'hFFFF_FFFF, 0);
    run(2'b00, 32'hFFFF_FF9C, 32'd0, 3);
    run(2'b10, 32'd50, 32'd7, 3);

    // start with a simultaneous flush in IDLE must not be accepted
    start_i = 1'b1; annul_i = 1'b1; op_i = 2'b01; dividend_i = 32'd8; divisor_i = 32'd2;
    #1 chk("stall_idle_annul", 32'(stall_req_o), 32'd0);
    @(negedge clk);
    start_i = 1'b0; annul_i = 1'b0;
    chk("idle_annul_not_busy", {30'd0, busy_o, done_o}, 32'd0);

    for (int i = 0; i < 40; i++) begin
      logic [31:0] a, b;
      a = $urandom;
      b = $urandom;
      case ($urandom_range(0, 5))
        0: b = 32'd0;
        1: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
        2: b = 32'($urandom_range(1, 20));
        3: b = 32'hFFFF_FFF0 | 32'($urandom_range(0, 15));
        default: ;
      endcase
      run(2'($urandom), a, b, 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
